// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// datapath strobe generation, wait-stated data memory handshake and fault reporting.
`timescale 1ns/1ps
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        IRWEn,
  output logic        PCWEn,
  output logic        PCSel,
  output logic        ASel,
  output logic        BSel,
  output logic [2:0]  ImmSel,
  output logic [3:0]  ALUSel,
  output logic [2:0]  branch_type,
  output logic        MemReq,
  output logic        MemRW,
  output logic        MDRWEn,
  output logic        RegWEn,
  output logic [1:0]  WBSel,
  output logic        instr_retired,
  output logic        illegal_instr,
  output logic        mem_fault
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t               state, state_nxt;
  logic [31:0]          ir;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 illegal_q, fault_q;
  logic                 illegal_set, fault_set;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       rd_nz;
  logic       is_r, is_i, is_load, is_store, is_jalr, is_jal, is_auipc, is_lui, is_branch;
  logic       illegal;
  logic       timeout_hit;
  logic       unused_ir_bits;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign alt    = ir[30];
  assign rd_nz  = (ir[11:7] != 5'd0);
  assign unused_ir_bits = ^{ir[31], ir[29:15]};

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic sub_sra);
    case (f3)
      3'b000:  alu_of = sub_sra ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = sub_sra ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  always_comb begin
    is_r      = (opcode == OP_R);
    is_i      = (opcode == OP_I);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_jalr   = (opcode == OP_JALR);
    is_jal    = (opcode == OP_JAL);
    is_auipc  = (opcode == OP_AUIPC);
    is_lui    = (opcode == OP_LUI);
    is_branch = (opcode == OP_BRANCH);
    illegal   = !(is_r || is_i || is_load || is_store || is_jalr || is_jal ||
                  is_auipc || is_lui || is_branch) ||
                (is_branch && (funct3[2:1] == 2'b01));
  end

  // Datapath selects depend only on IR, so they hold steady from DECODE through WB.
  always_comb begin
    ASel   = 1'b0;
    BSel   = 1'b0;
    ImmSel = IMM_I;
    ALUSel = ALU_ADD;
    WBSel  = 2'd0;
    if (is_r) begin
      ASel   = 1'b1;
      ALUSel = alu_of(funct3, alt);
    end else if (is_i) begin
      ASel   = 1'b1;
      BSel   = 1'b1;
      ALUSel = alu_of(funct3, alt && (funct3 == 3'b101));
    end else if (is_load || is_jalr) begin
      ASel   = 1'b1;
      BSel   = 1'b1;
      WBSel  = is_load ? 2'd1 : 2'd2;
    end else if (is_store) begin
      ASel   = 1'b1;
      BSel   = 1'b1;
      ImmSel = IMM_S;
    end else if (is_jal) begin
      BSel   = 1'b1;
      ImmSel = IMM_J;
      WBSel  = 2'd2;
    end else if (is_auipc) begin
      BSel   = 1'b1;
      ImmSel = IMM_U;
    end else if (is_lui) begin
      BSel   = 1'b1;
      ImmSel = IMM_U;
      ALUSel = ALU_PASSB;
    end else if (is_branch) begin
      BSel   = 1'b1;
      ImmSel = IMM_B;
    end
  end

  assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == TO_LAST);

  always_comb begin
    state_nxt     = state;
    IRWEn         = 1'b0;
    PCWEn         = 1'b0;
    PCSel         = 1'b0;
    MemReq        = 1'b0;
    MemRW         = 1'b0;
    MDRWEn        = 1'b0;
    RegWEn        = 1'b0;
    instr_retired = 1'b0;
    branch_type   = 3'b010;
    illegal_set   = 1'b0;
    fault_set     = 1'b0;
    case (state)
      S_FETCH: begin
        IRWEn     = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (illegal) begin
          illegal_set = 1'b1;
          state_nxt   = S_TRAP;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          PCWEn         = 1'b1;
          PCSel         = br_taken;
          instr_retired = 1'b1;
          branch_type   = funct3;
          state_nxt     = S_FETCH;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        MemReq = 1'b1;
        MemRW  = is_store;
        // A ready in the final permitted wait cycle takes priority over the timeout.
        if (mem_ready) begin
          if (is_store) begin
            PCWEn         = 1'b1;
            instr_retired = 1'b1;
            state_nxt     = S_FETCH;
          end else begin
            MDRWEn    = 1'b1;
            state_nxt = S_WB;
          end
        end else if (timeout_hit) begin
          fault_set = 1'b1;
          state_nxt = S_TRAP;
        end
      end
      S_WB: begin
        RegWEn        = rd_nz;
        PCWEn         = 1'b1;
        PCSel         = is_jal || is_jalr;
        instr_retired = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (IRWEn)       ir        <= instruction;
      if (illegal_set) illegal_q <= 1'b1;
      if (fault_set)   fault_q   <= 1'b1;
      if (state != S_MEM)  wait_cnt <= '0;
      else if (!mem_ready) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign illegal_instr = illegal_q;
  assign mem_fault     = fault_q;

endmodule
